// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address field widths, block width and the controller state encoding.
package dcache_pkg;

   localparam int TAG_W    = 3;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 2;
   localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;
   localparam int BLOCK_W  = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      FILL      = 2'd3
   } state_e;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid/dirty/tag/data per line, a hit
// compare against the presented tag, a single-byte store port and a block fill port.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 8,
   parameter int IDX_BITS  = 3,
   parameter int TAG_BITS  = 3,
   parameter int OFF_BITS  = 2,
   parameter int LINE_BITS = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [IDX_BITS-1:0]  index,
   input  logic [TAG_BITS-1:0]  tag,
   output logic                 hit,
   output logic                 line_valid,
   output logic                 line_dirty,
   output logic [TAG_BITS-1:0]  line_tag,
   output logic [LINE_BITS-1:0] line_data,
   input  logic                 byte_we,
   input  logic [OFF_BITS-1:0]  byte_offset,
   input  logic [7:0]           byte_data,
   input  logic                 fill_we,
   input  logic [LINE_BITS-1:0] fill_data
);

   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;
   logic [TAG_BITS-1:0]  tags  [NUM_LINES];
   logic [LINE_BITS-1:0] data  [NUM_LINES];

   assign line_valid = valid[index];
   assign line_dirty = dirty[index];
   assign line_tag   = tags[index];
   assign line_data  = data[index];
   assign hit        = valid[index] && (tags[index] == tag);

   // A fill always wins over a store; the controller never requests both,
   // but a fill leaves the line clean so ordering matters if it ever did.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
         dirty <= '0;
         for (int i = 0; i < NUM_LINES; i++) begin
            tags[i] <= '0;
            data[i] <= '0;
         end
      end else if (fill_we) begin
         data[index]  <= fill_data;
         tags[index]  <= tag;
         valid[index] <= 1'b1;
         dirty[index] <= 1'b0;
      end else if (byte_we) begin
         data[index][{byte_offset, 3'b000} +: 8] <= byte_data;
         dirty[index] <= 1'b1;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: hits complete with no stall,
// misses stall the CPU while a dirty victim is written back and the block is fetched.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int NUM_LINES   = 1 << INDEX_W,
   parameter int BLOCK_BYTES = BLOCK_W / 8
) (
   input  logic                                   CLK,
   input  logic                                   RESET,
   input  logic                                   READ,
   input  logic                                   WRITE,
   input  logic [ADDR_W-1:0]                      ADDRESS,
   input  logic [7:0]                             WRITEDATA,
   output logic [7:0]                             READDATA,
   output logic                                   BUSYWAIT,
   output logic                                   MEM_READ,
   output logic                                   MEM_WRITE,
   output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]  MEM_ADDRESS,
   output logic [BLOCK_BYTES*8-1:0]               MEM_WRITEDATA,
   input  logic [BLOCK_BYTES*8-1:0]               MEM_READDATA,
   input  logic                                   MEM_BUSYWAIT
);

   localparam int IDX_BITS  = $clog2(NUM_LINES);
   localparam int OFF_BITS  = $clog2(BLOCK_BYTES);
   localparam int TAG_BITS  = ADDR_W - IDX_BITS - OFF_BITS;
   localparam int LINE_BITS = BLOCK_BYTES * 8;

   localparam logic [1:0] ST_IDLE      = IDLE;
   localparam logic [1:0] ST_WRITEBACK = WRITEBACK;
   localparam logic [1:0] ST_FETCH     = FETCH;
   localparam logic [1:0] ST_FILL      = FILL;

   logic [1:0]           state;
   logic [1:0]           next_state;
   logic [LINE_BITS-1:0] fill_buf;

   logic [TAG_BITS-1:0]  addr_tag;
   logic [IDX_BITS-1:0]  addr_index;
   logic [OFF_BITS-1:0]  addr_offset;

   logic                 hit;
   logic                 line_valid;
   logic                 line_dirty;
   logic [TAG_BITS-1:0]  line_tag;
   logic [LINE_BITS-1:0] line_data;
   logic                 request;
   logic                 byte_we;
   logic                 fill_we;

   assign addr_tag    = ADDRESS[ADDR_W-1 : IDX_BITS+OFF_BITS];
   assign addr_index  = ADDRESS[IDX_BITS+OFF_BITS-1 : OFF_BITS];
   assign addr_offset = ADDRESS[OFF_BITS-1:0];

   assign request = READ || WRITE;

   // A simultaneous load and store is treated as a load, so the store is dropped.
   assign byte_we = (state == ST_IDLE) && WRITE && !READ && hit;
   assign fill_we = (state == ST_FILL);

   dcache_array #(
      .NUM_LINES (NUM_LINES),
      .IDX_BITS  (IDX_BITS),
      .TAG_BITS  (TAG_BITS),
      .OFF_BITS  (OFF_BITS),
      .LINE_BITS (LINE_BITS)
   ) u_array (
      .clock       (CLK),
      .reset       (RESET),
      .index       (addr_index),
      .tag         (addr_tag),
      .hit         (hit),
      .line_valid  (line_valid),
      .line_dirty  (line_dirty),
      .line_tag    (line_tag),
      .line_data   (line_data),
      .byte_we     (byte_we),
      .byte_offset (addr_offset),
      .byte_data   (WRITEDATA),
      .fill_we     (fill_we),
      .fill_data   (fill_buf)
   );

   // The fetched block is latched on the acknowledging edge and written into
   // the line one cycle later in FILL, so the array has a single fill source.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= ST_IDLE;
         fill_buf <= '0;
      end else begin
         state <= next_state;
         if (state == ST_FETCH && !MEM_BUSYWAIT) begin
            fill_buf <= MEM_READDATA;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (request && !hit) begin
               next_state = (line_valid && line_dirty) ? ST_WRITEBACK : ST_FETCH;
            end
         end
         ST_WRITEBACK: begin
            if (!MEM_BUSYWAIT) begin
               next_state = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (!MEM_BUSYWAIT) begin
               next_state = ST_FILL;
            end
         end
         ST_FILL: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Stall is Mealy only in IDLE (miss detect); every other state stalls outright.
   assign BUSYWAIT = (state != ST_IDLE) || (request && !hit);
   assign READDATA = hit ? line_data[{addr_offset, 3'b000} +: 8] : 8'h00;

   assign MEM_READ      = (state == ST_FETCH);
   assign MEM_WRITE     = (state == ST_WRITEBACK);
   assign MEM_ADDRESS   = (state == ST_WRITEBACK) ? {line_tag, addr_index}
                                                  : ADDRESS[ADDR_W-1:OFF_BITS];
   assign MEM_WRITEDATA = line_data;

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back data cache and controller between the 8-bit CPU datapath (load/store path) and the block-organised data memory. It sequences every CPU data access. A hit completes with no stall. A miss stalls the CPU through `BUSYWAIT` while the FSM writes back a dirty victim and then fetches the new 4-byte block. It is the only master on the data-memory port.

## Interface
Parameters:
- `NUM_LINES`, 8: cache lines; index width = log2(NUM_LINES) = 3
- `BLOCK_BYTES`, 4: bytes per line; offset width 2

Ports:
- `CLK`  in  1  system clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `READ`  in  1  CPU load request (held until `BUSYWAIT` low)
- `WRITE`  in  1  CPU store request (held until `BUSYWAIT` low)
- `ADDRESS`  in  8  byte address: tag[7:5], index[4:2], offset[1:0]
- `WRITEDATA`  in  8  store data
- `READDATA`  out  8  load data, combinational from the addressed line on a hit
- `BUSYWAIT`  out  1  stall to PC/register file
- `MEM_READ`  out  1  block read request to data memory
- `MEM_WRITE`  out  1  block write request to data memory
- `MEM_ADDRESS`  out  6  block address {tag,index}
- `MEM_WRITEDATA`  out  32  victim block, byte0 in [7:0]
- `MEM_READDATA`  in  32  fetched block, byte0 in [7:0]
- `MEM_BUSYWAIT`  in  1  memory busy; transfer done on the first cycle it is low while a request is held

## Operation
- Per line state: valid, dirty, tag[2:0], data[31:0].
- Hit = valid[index] and tag[index] == ADDRESS[7:5].
- States:
  - IDLE: default state.
  - WRITEBACK: drives `MEM_WRITE`=1, `MEM_ADDRESS`={stored tag, index}, `MEM_WRITEDATA`=line data.
  - FETCH: drives `MEM_READ`=1, `MEM_ADDRESS`=ADDRESS[7:2].
  - FILL: the only state that writes line data from memory.
- IDLE with no request: `BUSYWAIT`=0 and no state change.
- IDLE, read hit: `BUSYWAIT`=0, `READDATA`=data byte[offset].
- IDLE, write hit: `BUSYWAIT`=0. At the next edge, byte[offset] ← WRITEDATA and dirty ← 1.
- IDLE, miss: `BUSYWAIT`=1 combinationally. Next state is WRITEBACK if valid and dirty, else FETCH.
- WRITEBACK → FETCH on the edge where `MEM_BUSYWAIT`=0.
- FETCH → FILL on the edge where `MEM_BUSYWAIT`=0. `MEM_READDATA` is captured at that edge.
- FILL: loads data, tag ← ADDRESS[7:5], valid ← 1, dirty ← 0, then → IDLE. The request now hits.
- `BUSYWAIT`=1 in every non-IDLE state.
- `READ` and `WRITE` both high: handled as READ; store ignored.
- `ADDRESS` changing mid-miss is illegal; the CPU holds it because the PC is stalled.

## Timing
- Reset: state IDLE; all valid/dirty ← 0; `MEM_READ`=`MEM_WRITE`=0; `BUSYWAIT`=0; `READDATA`=0 when no hit.
- Reset mid-miss: the FSM returns to IDLE at that edge and memory requests drop the same cycle. Dirty data is lost by design.
- Hit latency: 0 stall cycles. Load data is valid in the same cycle; the store commits at the next edge.
- Clean-miss stall, with memory latency L cycles (`MEM_BUSYWAIT` high L−1 cycles): 1 (IDLE detect) + L (FETCH) + 1 (FILL) cycles of `BUSYWAIT`=1. The access then completes as a hit.
- Dirty miss adds L cycles of WRITEBACK.
- `MEM_READ`/`MEM_WRITE` are Moore outputs of the state register. They are held stable, never both high, until memory acknowledges.
- `BUSYWAIT` is Mealy in IDLE (miss detect) and Moore elsewhere.

## Structure
- Shared package `dcache_pkg`:
  - state enum {IDLE, WRITEBACK, FETCH, FILL}
  - field widths TAG_W=3, INDEX_W=3, OFFSET_W=2
  - BLOCK_W=32
- Sub-module `dcache_array`: holds valid/dirty/tag/data storage with synchronous reset clear. It has a hit-compare output, a byte-write port and a block-fill port.
- FSM, output muxing and byte select live in `dcache_controller`.

## Test plan
- Reset, then read 0x00 → `BUSYWAIT` high 1+L+1 cycles; `MEM_READ`=1 with `MEM_ADDRESS`=0x00 during FETCH; then `READDATA`=mem byte0.
- Read 0x01 right after the fill of 0x00 → hit, `BUSYWAIT`=0, `READDATA`=mem byte1, no memory request.
- Write 0xAB to 0x05 (miss), then read 0x05 → fill of block 0x01, then `READDATA`=0xAB with line dirty; no writeback yet.
- Read 0x25 (same index 1, tag 1) → WRITEBACK first with `MEM_ADDRESS`=0x01 and `MEM_WRITEDATA` byte1=0xAB, then FETCH with `MEM_ADDRESS`=0x09.
- `RESET` asserted during FETCH → next cycle IDLE, `MEM_READ`=0, `BUSYWAIT`=0; a read of the same address misses again.
- `READ`=`WRITE`=1 to a hit address with `WRITEDATA`=0x55 → old data returned, line unchanged, dirty unchanged.
